// File: rtl/ddr3_req_arbiter_pkg.sv
// Shared DDR3 definitions used by the request arbiter and the response demux.
//   arb_state_t : arbiter FSM state encoding
//   port_bits() : width of the port-index field (at least 1 bit)
//   tag_bits()  : width of the downstream tag {port index, requester tid}.
//                 The port index sits in the MSBs so that the response demux
//                 can route a completion with a single slice.
package ddr3_req_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_t;

  function automatic int port_bits(input int nports);
    return (nports > 2) ? $clog2(nports) : 1;
  endfunction

  function automatic int tag_bits(input int reqid, input int nports);
    return reqid + port_bits(nports);
  endfunction

endpackage

// File: rtl/ddr3_rr_pick.sv
// Combinational round-robin selector.
//   req        : per-port request vector
//   last_grant : index of the previous winner; the search starts one above it
//   lock_mask  : ports allowed to compete (all ones when no sequence lock)
//   grant      : one-hot winner, zero when nobody eligible requests
//   grant_idx  : binary index of the winner
//   valid      : a winner exists
module ddr3_rr_pick #(
  parameter int NPORTS = 4,
  parameter int PB     = 2
) (
  input  logic [NPORTS-1:0] req,
  input  logic [PB-1:0]     last_grant,
  input  logic [NPORTS-1:0] lock_mask,
  output logic [NPORTS-1:0] grant,
  output logic [PB-1:0]     grant_idx,
  output logic              valid
);

  logic [NPORTS-1:0] cand;

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_cand
      assign cand[gi] = req[gi] & lock_mask[gi];
    end
  endgenerate

  // Walk the ports starting at last_grant+1; i == NPORTS wraps back onto
  // last_grant itself, so the previous winner has the lowest priority.
  always_comb begin
    int p;
    p         = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 1; i <= NPORTS; i++) begin
      p = (int'(last_grant) + i) % NPORTS;
      if (!valid && cand[p]) begin
        grant[p]  = 1'b1;
        grant_idx = PB'(p);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Multi-port request arbiter in front of the DDR3 controller FSM.
// Ports:
//   clock, reset                      : rising-edge clock, async active-high reset
//   prt_req/wr/lst/tid/adr_i          : per-port request, direction, last-of-row
//                                       flag, transaction id and word address
//   prt_ack_o, prt_err_o              : one-cycle completion / error pulses
//   mem_wr*, mem_rd*                  : write and read request ports downstream;
//                                       tid is {port index, requester tid}
// One request is in flight at a time. Grants are round-robin, except that a
// port issuing lst=0 keeps the bus for its next request, up to SEQ_MAX grants.
module ddr3_req_arbiter
  import ddr3_req_arbiter_pkg::*;
#(
  parameter int  NPORTS  = 4,
  parameter int  ADDRS   = 27,
  parameter int  REQID   = 4,
  parameter int  SEQ_MAX = 8,
  localparam int PB      = port_bits(NPORTS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NPORTS-1:0]       prt_req_i,
  input  logic [NPORTS-1:0]       prt_wr_i,
  input  logic [NPORTS-1:0]       prt_lst_i,
  input  logic [NPORTS*REQID-1:0] prt_tid_i,
  input  logic [NPORTS*ADDRS-1:0] prt_adr_i,
  output logic [NPORTS-1:0]       prt_ack_o,
  output logic [NPORTS-1:0]       prt_err_o,
  output logic                    mem_wrreq_o,
  output logic                    mem_wrlst_o,
  input  logic                    mem_wrack_i,
  input  logic                    mem_wrerr_i,
  output logic [REQID+PB-1:0]     mem_wrtid_o,
  output logic [ADDRS-1:0]        mem_wradr_o,
  output logic                    mem_rdreq_o,
  output logic                    mem_rdlst_o,
  input  logic                    mem_rdack_i,
  input  logic                    mem_rderr_i,
  output logic [REQID+PB-1:0]     mem_rdtid_o,
  output logic [ADDRS-1:0]        mem_rdadr_o
);

  localparam int CW = $clog2(SEQ_MAX + 1);

  arb_state_t       state_reg, state_next;
  logic [PB-1:0]    last_grant_reg;
  logic             lock_reg;
  logic [CW-1:0]    seq_cnt_reg;
  logic             dir_reg, lst_reg, err_reg;
  logic [REQID-1:0] tid_reg;
  logic [ADDRS-1:0] adr_reg;

  logic [REQID-1:0] tid_arr [NPORTS];
  logic [ADDRS-1:0] adr_arr [NPORTS];

  genvar gi;
  generate
    for (gi = 0; gi < NPORTS; gi++) begin : g_unpack
      assign tid_arr[gi] = prt_tid_i[gi*REQID +: REQID];
      assign adr_arr[gi] = prt_adr_i[gi*ADDRS +: ADDRS];
    end
  endgenerate

  logic              lock_live;
  logic [NPORTS-1:0] grant_onehot, lock_mask, pick_grant;
  logic [PB-1:0]     pick_idx;
  logic              pick_valid, pick_dir, pick_lst;
  logic [CW-1:0]     run_len;
  logic              act_ack, act_err;

  // The lock only restricts arbitration while the locked port still requests;
  // if it has dropped, the lock falls away and everyone competes this cycle.
  assign lock_live    = lock_reg & prt_req_i[last_grant_reg];
  assign grant_onehot = NPORTS'(1) << last_grant_reg;
  assign lock_mask    = lock_live ? grant_onehot : '1;

  ddr3_rr_pick #(
    .NPORTS (NPORTS),
    .PB     (PB)
  ) u_pick (
    .req        (prt_req_i),
    .last_grant (last_grant_reg),
    .lock_mask  (lock_mask),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .valid      (pick_valid)
  );

  // Length of the locked run including this grant; reaching SEQ_MAX forces
  // the row sequence closed.
  assign run_len  = (lock_live ? seq_cnt_reg : '0) + CW'(1);
  assign pick_dir = |(prt_wr_i & pick_grant);
  assign pick_lst = (|(prt_lst_i & pick_grant)) | (run_len == CW'(SEQ_MAX));

  // Only the handshake of the direction actually issued is honoured.
  assign act_ack = dir_reg ? mem_wrack_i : mem_rdack_i;
  assign act_err = dir_reg ? mem_wrerr_i : mem_rderr_i;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ARB_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mem_wrreq_o = 1'b0;
    mem_rdreq_o = 1'b0;
    prt_ack_o   = '0;
    prt_err_o   = '0;
    case (state_reg)
      ARB_IDLE: begin
        if (pick_valid) state_next = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_wrreq_o = dir_reg;
        mem_rdreq_o = !dir_reg;
        if (act_ack || act_err) state_next = ARB_DONE;
      end
      ARB_DONE: begin
        state_next = ARB_IDLE;
        if (err_reg) prt_err_o = grant_onehot;
        else         prt_ack_o = grant_onehot;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_reg <= PB'(NPORTS - 1);
      lock_reg       <= 1'b0;
      seq_cnt_reg    <= '0;
      dir_reg        <= 1'b0;
      lst_reg        <= 1'b0;
      err_reg        <= 1'b0;
      tid_reg        <= '0;
      adr_reg        <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (lock_reg && !lock_live) begin
            lock_reg    <= 1'b0;
            seq_cnt_reg <= '0;
          end
          if (pick_valid) begin
            last_grant_reg <= pick_idx;
            dir_reg        <= pick_dir;
            lst_reg        <= pick_lst;
            tid_reg        <= tid_arr[pick_idx];
            adr_reg        <= adr_arr[pick_idx];
            lock_reg       <= !pick_lst;
            seq_cnt_reg    <= pick_lst ? '0 : run_len;
          end
        end
        ARB_ISSUE: begin
          if (act_ack || act_err) begin
            // err dominates a simultaneous ack and breaks any sequence lock
            err_reg <= act_err;
            if (act_err) begin
              lock_reg    <= 1'b0;
              seq_cnt_reg <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Request attributes are only presented on the active port, so both
  // request ports read all-zero whenever nothing is outstanding.
  assign mem_wrtid_o = mem_wrreq_o ? {last_grant_reg, tid_reg} : '0;
  assign mem_wradr_o = mem_wrreq_o ? adr_reg : '0;
  assign mem_wrlst_o = mem_wrreq_o & lst_reg;
  assign mem_rdtid_o = mem_rdreq_o ? {last_grant_reg, tid_reg} : '0;
  assign mem_rdadr_o = mem_rdreq_o ? adr_reg : '0;
  assign mem_rdlst_o = mem_rdreq_o & lst_reg;

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
module tb_ddr3_req_arbiter;

  localparam int NP  = 8;
  localparam int SM  = 4;
  localparam int AW  = 27;
  localparam int IW  = 4;
  localparam int PBW = 3;
  localparam int TW  = IW + PBW;
  localparam int QD  = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic [NP-1:0]   prt_req_i, prt_wr_i, prt_lst_i;
  logic [NP*IW-1:0] prt_tid_i;
  logic [NP*AW-1:0] prt_adr_i;
  logic [NP-1:0]   prt_ack_o, prt_err_o;
  logic            mem_wrreq_o, mem_wrlst_o, mem_wrack_i, mem_wrerr_i;
  logic [TW-1:0]   mem_wrtid_o;
  logic [AW-1:0]   mem_wradr_o;
  logic            mem_rdreq_o, mem_rdlst_o, mem_rdack_i, mem_rderr_i;
  logic [TW-1:0]   mem_rdtid_o;
  logic [AW-1:0]   mem_rdadr_o;

  always #5 clock = ~clock;

  ddr3_req_arbiter #(
    .NPORTS (NP), .ADDRS (AW), .REQID (IW), .SEQ_MAX (SM)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .prt_req_i   (prt_req_i),
    .prt_wr_i    (prt_wr_i),
    .prt_lst_i   (prt_lst_i),
    .prt_tid_i   (prt_tid_i),
    .prt_adr_i   (prt_adr_i),
    .prt_ack_o   (prt_ack_o),
    .prt_err_o   (prt_err_o),
    .mem_wrreq_o (mem_wrreq_o),
    .mem_wrlst_o (mem_wrlst_o),
    .mem_wrack_i (mem_wrack_i),
    .mem_wrerr_i (mem_wrerr_i),
    .mem_wrtid_o (mem_wrtid_o),
    .mem_wradr_o (mem_wradr_o),
    .mem_rdreq_o (mem_rdreq_o),
    .mem_rdlst_o (mem_rdlst_o),
    .mem_rdack_i (mem_rdack_i),
    .mem_rderr_i (mem_rderr_i),
    .mem_rdtid_o (mem_rdtid_o),
    .mem_rdadr_o (mem_rdadr_o)
  );

  typedef struct {
    bit             dir;
    bit             lst;
    logic [IW-1:0]  tid;
    logic [AW-1:0]  adr;
  } rq_t;

  // Requester agents: per-port request lists, head index, tail index, idle gap
  rq_t pq [NP][QD];
  int  ph [NP];
  int  pt [NP];
  int  gap [NP];
  int  gen_cnt [NP];
  int  obs_ack [NP];
  int  obs_err [NP];
  int  waited [NP];
  int  max_wait;

  // Reference model: the transaction the bus should carry this cycle
  bit      m_busy;
  int      m_port;
  rq_t     m_rq;
  bit      m_lst;
  int      m_pulse;        // 0 none, 1 ack, 2 err
  int      m_pulse_port;
  int      m_last;
  bit      m_lock;
  int      m_cnt;
  int      age, delay, kind;  // kind: 1 ack, 2 err, 3 ack+err
  bit [NP-1:0] d_req;
  int      d_resp;
  int      glog[$];
  bit      lstlog[$];
  bit      random_mode;
  bit      hang_mode;
  int      err_grant;
  int      grant_no;

  int tests_run;
  int tests_failed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_req(input int p, input bit dir, input bit lst,
                          input logic [IW-1:0] tid, input logic [AW-1:0] adr);
    pq[p][pt[p]] = '{dir: dir, lst: lst, tid: tid, adr: adr};
    pt[p]++;
    gen_cnt[p]++;
  endtask

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      if (ph[p] < pt[p] && gap[p] == 0) begin
        prt_req_i[p]          = 1'b1;
        prt_wr_i[p]           = pq[p][ph[p]].dir;
        prt_lst_i[p]          = pq[p][ph[p]].lst;
        prt_tid_i[p*IW +: IW] = pq[p][ph[p]].tid;
        prt_adr_i[p*AW +: AW] = pq[p][ph[p]].adr;
      end else begin
        prt_req_i[p] = 1'b0;
        prt_wr_i[p]  = 1'b0;
        prt_lst_i[p] = 1'b0;
        if (gap[p] > 0) gap[p]--;
      end
    end
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    prt_req_i   = '0;
    prt_wr_i    = '0;
    prt_lst_i   = '0;
    prt_tid_i   = '0;
    prt_adr_i   = '0;
    mem_wrack_i = 1'b0;
    mem_wrerr_i = 1'b0;
    mem_rdack_i = 1'b0;
    mem_rderr_i = 1'b0;
    for (int p = 0; p < NP; p++) begin
      ph[p] = 0; pt[p] = 0; gap[p] = 0; gen_cnt[p] = 0;
      obs_ack[p] = 0; obs_err[p] = 0; waited[p] = 0;
    end
    max_wait = 0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset     = 1'b0;
    m_busy    = 1'b0;
    m_pulse   = 0;
    m_last    = NP - 1;
    m_lock    = 1'b0;
    m_cnt     = 0;
    d_req     = '0;
    d_resp    = 0;
    grant_no  = 0;
    glog.delete();
    lstlog.delete();
  endtask

  // One clock: advance the model across the edge, compare, then drive inputs.
  task automatic step();
    int  g;
    int  run;
    int  r;
    bit  found;
    bit  a, e;
    logic [NP-1:0] exp_ack, exp_err;
    logic [TW-1:0] exp_tid;
    @(posedge clock);
    #1;
    if (m_pulse != 0) begin
      m_pulse = 0;
    end else if (m_busy) begin
      if (d_resp != 0) begin
        m_busy       = 1'b0;
        m_pulse      = d_resp;
        m_pulse_port = m_port;
        if (d_resp == 2) begin
          m_lock = 1'b0;
          m_cnt  = 0;
        end
        ph[m_port]++;
        if (random_mode && $urandom_range(1, 0) == 1) gap[m_port] = $urandom_range(3, 1);
      end
    end else begin
      if (m_lock && !d_req[m_last]) begin
        m_lock = 1'b0;
        m_cnt  = 0;
      end
      found = 1'b0;
      g     = 0;
      for (int i = 1; i <= NP; i++) begin
        int p;
        p = (m_last + i) % NP;
        if (!found && d_req[p] && (!m_lock || p == m_last)) begin
          found = 1'b1;
          g     = p;
        end
      end
      if (found) begin
        for (int q = 0; q < NP; q++) begin
          if (q != g) begin
            if (d_req[q]) waited[q]++;
            else          waited[q] = 0;
          end
        end
        if (waited[g] > max_wait) max_wait = waited[g];
        waited[g] = 0;
        run    = (m_lock ? m_cnt : 0) + 1;
        m_busy = 1'b1;
        m_port = g;
        m_rq   = pq[g][ph[g]];
        m_lst  = m_rq.lst || (run == SM);
        m_lock = !m_lst;
        m_cnt  = m_lst ? 0 : run;
        m_last = g;
        glog.push_back(g);
        lstlog.push_back(m_lst);
        age = 0;
        if (random_mode) begin
          delay = $urandom_range(3, 0);
          r     = $urandom_range(9, 0);
          kind  = (r < 8) ? 1 : ((r == 8) ? 2 : 3);
        end else begin
          delay = hang_mode ? 1000 : 1;
          kind  = (grant_no == err_grant) ? 3 : 1;
        end
        grant_no++;
      end
    end

    // compare against the model
    check_eq("wrreq", 64'(mem_wrreq_o), 64'(m_busy && m_rq.dir));
    check_eq("rdreq", 64'(mem_rdreq_o), 64'(m_busy && !m_rq.dir));
    if (m_busy) begin
      exp_tid = {PBW'(m_port), m_rq.tid};
      if (m_rq.dir) begin
        check_eq("wrtid", 64'(mem_wrtid_o), 64'(exp_tid));
        check_eq("wradr", 64'(mem_wradr_o), 64'(m_rq.adr));
        check_eq("wrlst", 64'(mem_wrlst_o), 64'(m_lst));
      end else begin
        check_eq("rdtid", 64'(mem_rdtid_o), 64'(exp_tid));
        check_eq("rdadr", 64'(mem_rdadr_o), 64'(m_rq.adr));
        check_eq("rdlst", 64'(mem_rdlst_o), 64'(m_lst));
      end
    end
    exp_ack = (m_pulse == 1) ? (NP'(1) << m_pulse_port) : '0;
    exp_err = (m_pulse == 2) ? (NP'(1) << m_pulse_port) : '0;
    check_eq("prt_ack", 64'(prt_ack_o), 64'(exp_ack));
    check_eq("prt_err", 64'(prt_err_o), 64'(exp_err));
    for (int p = 0; p < NP; p++) begin
      obs_ack[p] += int'(prt_ack_o[p]);
      obs_err[p] += int'(prt_err_o[p]);
    end
    if (m_pulse != 0)
      $display("[TB] txn port=%0d %s", m_pulse_port, (m_pulse == 1) ? "ack" : "err");

    // memory responder
    mem_wrack_i = 1'b0;
    mem_wrerr_i = 1'b0;
    mem_rdack_i = 1'b0;
    mem_rderr_i = 1'b0;
    d_resp      = 0;
    if (m_busy) begin
      a = (age == delay) && (kind == 1 || kind == 3);
      e = (age == delay) && (kind >= 2);
      if (m_rq.dir) begin
        mem_wrack_i = a;
        mem_wrerr_i = e;
        if (random_mode) begin
          mem_rdack_i = ($urandom_range(3, 0) == 0);
          mem_rderr_i = ($urandom_range(3, 0) == 0);
        end
      end else begin
        mem_rdack_i = a;
        mem_rderr_i = e;
        if (random_mode) begin
          mem_wrack_i = ($urandom_range(3, 0) == 0);
          mem_wrerr_i = ($urandom_range(3, 0) == 0);
        end
      end
      if (age == delay) d_resp = (kind == 1) ? 1 : 2;
      age++;
    end else if (random_mode) begin
      mem_wrack_i = ($urandom_range(3, 0) == 0);
      mem_wrerr_i = ($urandom_range(3, 0) == 0);
      mem_rdack_i = ($urandom_range(3, 0) == 0);
      mem_rderr_i = ($urandom_range(3, 0) == 0);
    end
    drive_ports();
    d_req = prt_req_i;
  endtask

  task automatic run_until_idle(input int budget);
    bit drained;
    drained = 1'b0;
    for (int c = 0; c < budget && !drained; c++) begin
      step();
      drained = !m_busy && (m_pulse == 0);
      for (int p = 0; p < NP; p++) if (ph[p] < pt[p]) drained = 1'b0;
    end
    check_eq("drain_in_budget", 64'(drained), 64'(1));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    random_mode  = 1'b0;
    hang_mode    = 1'b0;
    err_grant    = -1;

    // reset state
    do_reset();
    check_eq("rst_prt", 64'({prt_ack_o, prt_err_o}), 64'(0));
    check_eq("rst_wr", 64'({mem_wrreq_o, mem_wrlst_o, mem_wrtid_o, mem_wradr_o}), 64'(0));
    check_eq("rst_rd", 64'({mem_rdreq_o, mem_rdlst_o, mem_rdtid_o, mem_rdadr_o}), 64'(0));

    // round-robin order with three contenders
    push_req(0, 1'b0, 1'b1, 4'h5, 27'h0000100);
    push_req(1, 1'b1, 1'b1, 4'hA, 27'h0000200);
    push_req(2, 1'b0, 1'b1, 4'h3, 27'h0000300);
    run_until_idle(100);
    check_eq("rr_count", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) begin
      check_eq("rr_g0", 64'(glog[0]), 64'(0));
      check_eq("rr_g1", 64'(glog[1]), 64'(1));
      check_eq("rr_g2", 64'(glog[2]), 64'(2));
    end

    // sequence lock holds port 1 for lst=0,0,1
    do_reset();
    push_req(1, 1'b0, 1'b0, 4'h1, 27'h0001000);
    push_req(1, 1'b0, 1'b0, 4'h2, 27'h0001001);
    push_req(1, 1'b0, 1'b1, 4'h3, 27'h0001002);
    push_req(3, 1'b1, 1'b1, 4'h7, 27'h0003000);
    run_until_idle(100);
    check_eq("lock_count", 64'(glog.size()), 64'(4));
    if (glog.size() == 4) begin
      check_eq("lock_g0", 64'(glog[0]), 64'(1));
      check_eq("lock_g1", 64'(glog[1]), 64'(1));
      check_eq("lock_g2", 64'(glog[2]), 64'(1));
      check_eq("lock_g3", 64'(glog[3]), 64'(3));
    end

    // SEQ_MAX forces lst on the 4th locked grant
    do_reset();
    for (int k = 0; k < 6; k++) push_req(0, 1'b1, 1'b0, 4'(k), 27'(16'h4000 + k));
    push_req(2, 1'b1, 1'b1, 4'hC, 27'h0002000);
    run_until_idle(200);
    check_eq("seqmax_count", 64'(glog.size()), 64'(7));
    if (glog.size() == 7) begin
      check_eq("seqmax_lst3", 64'(lstlog[3]), 64'(1));
      check_eq("seqmax_lst2", 64'(lstlog[2]), 64'(0));
      check_eq("seqmax_g3", 64'(glog[3]), 64'(0));
      check_eq("seqmax_g4", 64'(glog[4]), 64'(2));
    end

    // simultaneous ack+err on a locked write: err wins, lock dropped
    do_reset();
    err_grant = 0;
    push_req(0, 1'b1, 1'b0, 4'h9, 27'h0005000);
    push_req(0, 1'b1, 1'b1, 4'hB, 27'h0005001);
    push_req(1, 1'b0, 1'b1, 4'h4, 27'h0006000);
    run_until_idle(100);
    err_grant = -1;
    check_eq("err_p0_err", 64'(obs_err[0]), 64'(1));
    check_eq("err_p0_ack", 64'(obs_ack[0]), 64'(1));
    check_eq("err_count", 64'(glog.size()), 64'(3));
    if (glog.size() == 3) check_eq("err_unlock_g1", 64'(glog[1]), 64'(1));

    // reset while a read is outstanding
    do_reset();
    hang_mode = 1'b1;
    push_req(1, 1'b0, 1'b1, 4'h6, 27'h0007000);
    for (int i = 0; i < 10 && !m_busy; i++) step();
    check_eq("midrst_rdreq", 64'(mem_rdreq_o), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_prt", 64'({prt_ack_o, prt_err_o}), 64'(0));
    check_eq("midrst_wr", 64'({mem_wrreq_o, mem_wrlst_o, mem_wrtid_o, mem_wradr_o}), 64'(0));
    check_eq("midrst_rd", 64'({mem_rdreq_o, mem_rdlst_o, mem_rdtid_o, mem_rdadr_o}), 64'(0));
    do_reset();
    hang_mode = 1'b0;
    push_req(0, 1'b0, 1'b1, 4'h1, 27'h0008000);
    push_req(2, 1'b0, 1'b1, 4'h2, 27'h0009000);
    run_until_idle(100);
    check_eq("midrst_count", 64'(glog.size()), 64'(2));
    if (glog.size() >= 1) check_eq("midrst_first", 64'(glog[0]), 64'(0));

    // randomized stress across all eight ports
    do_reset();
    random_mode = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 30; k++)
        push_req(p, bit'($urandom_range(1, 0)), bit'($urandom_range(2, 0) != 0),
                 4'($urandom), 27'($urandom));
    run_until_idle(20000);
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("stress_done_p%0d", p), 64'(obs_ack[p] + obs_err[p]), 64'(gen_cnt[p]));
    check_eq("stress_starve", 64'(max_wait <= NP * SM), 64'(1));
    random_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
